// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: state encoding and prescaler sizing.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clock cycles per tick; the caller guarantees an exact integer >= 2.
    function automatic int calc_pre(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed to hold prescaler values 0..PRE-1.
    function automatic int calc_pre_w(input int clk_hz, input int tick_hz);
        return $clog2(calc_pre(clk_hz, tick_hz));
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Modulo-MOD cycle counter producing the tick timebase for the timer.
// Latency: tc is combinational from the current value and en.
// Backpressure: en low freezes the count in place (used for pause), clr restarts at 0.
// Ports: clk, reset (sync, active-low), en (advance), clr (sync clear), tc (terminal count & en).
module timer_prescaler #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end
    end

    assign tc = en && (value == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: prescaled tick counter with one-shot/periodic modes.
// Latency: first expire visible the cycle after edge period*PRE following start.
// Backpressure: cfg_ready is high only in IDLE/DONE; config offered elsewhere is not taken.
// Ports: clk, reset (sync active-low), cfg_valid/cfg_ready/cfg_period/cfg_oneshot,
//        start/stop/clear strobes, expire pulse, wave, busy, count, state.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic          cfg_oneshot,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    output logic          expire,
    output logic          wave,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic [1:0]    state
);

    localparam int PRE = calc_pre(CLK_HZ, TICK_HZ);
    localparam int PW  = calc_pre_w(CLK_HZ, TICK_HZ);

    state_t        st_q, st_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] period_reg, period_eff;
    logic          oneshot_reg;
    logic          expire_q, expire_d;
    logic          wave_q, wave_d;
    logic          cfg_acc, run, stop_run, start_go, resume;
    logic          pre_en, pre_clr, tick, last_tick;

    assign cfg_acc    = cfg_valid && cfg_ready;
    // A start in the same cycle as an accepted config uses the new period.
    assign period_eff = cfg_acc ? cfg_period : period_reg;
    assign run        = (st_q == ST_RUN);
    assign stop_run   = !clear && stop && run;
    assign start_go   = !clear && start && ((st_q == ST_IDLE) || (st_q == ST_DONE))
                        && (period_eff != '0);
    assign resume     = !clear && !stop_run && start && (st_q == ST_PAUSE);

    // The prescaler freezes on the stop cycle so a tick landing there is dropped
    // and the held PRE-1 value ticks again in the first cycle after resume.
    assign pre_en     = run && !clear && !stop;
    assign pre_clr    = clear || start_go;
    assign last_tick  = tick && (count_q == CW'(1));

    timer_prescaler #(
        .MOD (PRE),
        .W   (PW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .tc    (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next-state logic: clear > stop > start > tick
    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = ST_IDLE;
        end else if (stop_run) begin
            st_d = ST_PAUSE;
        end else if (start_go || resume) begin
            st_d = ST_RUN;
        end else if (last_tick && oneshot_reg) begin
            st_d = ST_DONE;
        end
    end

    // Tick counter and expire/wave next values
    always_comb begin
        count_d  = count_q;
        expire_d = 1'b0;
        wave_d   = wave_q;
        if (clear) begin
            count_d = '0;
        end else if (start_go) begin
            count_d = period_eff;
        end else if (tick) begin
            if (count_q > CW'(1)) begin
                count_d = count_q - CW'(1);
            end else if (count_q == CW'(1)) begin
                // Periodic reload lands on the same edge as the expiry: no gap cycle.
                count_d  = oneshot_reg ? '0 : period_reg;
                expire_d = 1'b1;
                wave_d   = ~wave_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q     <= '0;
            expire_q    <= 1'b0;
            wave_q      <= 1'b0;
            period_reg  <= '0;
            oneshot_reg <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
            wave_q   <= wave_d;
            if (cfg_acc) begin
                period_reg  <= cfg_period;
                oneshot_reg <= cfg_oneshot;
            end
        end
    end

    // Outputs
    always_comb begin
        state     = st_q;
        busy      = (st_q == ST_RUN) || (st_q == ST_PAUSE);
        cfg_ready = (st_q == ST_IDLE) || (st_q == ST_DONE);
        count     = count_q;
        expire    = expire_q;
        wave      = wave_q;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
`timescale 1ns/1ps
module tb_timer_ctrl;

    localparam int CLK_HZ  = 8;
    localparam int TICK_HZ = 2;
    localparam int CW      = 16;
    localparam int PRE     = CLK_HZ / TICK_HZ;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_period = '0;
    logic          cfg_oneshot = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic          cfg_ready, expire, wave, busy;
    logic [CW-1:0] count;
    logic [1:0]    state;

    always #5 clk = ~clk;

    timer_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CW      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .expire      (expire),
        .wave        (wave),
        .busy        (busy),
        .count       (count),
        .state       (state)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        logic          exp;
        logic          wv;
        logic          bsy;
        logic          rdy;
    } obs_t;

    typedef struct {
        string name;
        int    got;
        int    want;
    } dchk_t;

    obs_t  exp_q[$];
    dchk_t dq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc_no = 0;

    // Reference model: state 0..3, remaining ticks, RUN cycles spent toward the next tick.
    int m_state = 0, m_rem = 0, m_phase = 0, m_period = 0;
    bit m_oneshot = 0, m_wave = 0, m_expire = 0;

    task automatic model_edge();
        bit acc;
        int ep;
        m_expire = 0;
        if (!reset) begin
            m_state = 0; m_rem = 0; m_phase = 0; m_period = 0;
            m_oneshot = 0; m_wave = 0;
            return;
        end
        acc = cfg_valid && (m_state == 0 || m_state == 3);
        ep  = acc ? int'(cfg_period) : m_period;
        if (acc) begin
            m_period  = int'(cfg_period);
            m_oneshot = cfg_oneshot;
        end
        if (clear) begin
            m_state = 0; m_rem = 0; m_phase = 0;
        end else if (stop && m_state == 1) begin
            m_state = 2;
        end else if (start && (m_state == 0 || m_state == 3)) begin
            if (ep != 0) begin
                m_state = 1; m_rem = ep; m_phase = 0;
            end
        end else if (start && m_state == 2) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (m_phase == PRE - 1) begin
                m_phase = 0;
                if (m_rem > 1) begin
                    m_rem = m_rem - 1;
                end else begin
                    m_expire = 1;
                    m_wave   = !m_wave;
                    if (m_oneshot) begin
                        m_rem = 0; m_state = 3;
                    end else begin
                        m_rem = m_period;
                    end
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic step();
        obs_t e;
        @(posedge clk);
        cyc_no++;
        model_edge();
        e.st  = m_state[1:0];
        e.cnt = m_rem[CW-1:0];
        e.exp = m_expire;
        e.wv  = m_wave;
        e.bsy = (m_state == 1 || m_state == 2);
        e.rdy = (m_state == 0 || m_state == 3);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        dchk_t d;
        d.name = name; d.got = got; d.want = want;
        dq.push_back(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_cfg(input int p, input bit os);
        cfg_valid = 1; cfg_period = CW'(p); cfg_oneshot = os;
        step();
        cfg_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic pulse_clear();
        clear = 1; step(); clear = 0;
    endtask

    // Cycles from the last sampled edge until expire is seen; -1 on timeout.
    task automatic wait_expire(input string name, input int want);
        int k;
        bit seen;
        k = 0; seen = 0;
        while (!seen && k < 4 * want + 8) begin
            step();
            k++;
            seen = (expire === 1'b1);
        end
        check(name, seen ? k : -1, want);
    endtask

    // Monitor: compares every presented output cycle and every directed check.
    always @(negedge clk) begin
        obs_t  e, got;
        dchk_t d;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state, count, expire, wave, busy, cfg_ready};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL obs cycle %0d: got st=%0d cnt=%0d exp=%0b wave=%0b busy=%0b rdy=%0b, required st=%0d cnt=%0d exp=%0b wave=%0b busy=%0b rdy=%0b",
                         cyc_no, got.st, got.cnt, got.exp, got.wv, got.bsy, got.rdy,
                         e.st, e.cnt, e.exp, e.wv, e.bsy, e.rdy);
            end
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            vectors++;
            if (d.got != d.want) begin
                miscompares++;
                $display("FAIL %s: got %0d, required %0d", d.name, d.got, d.want);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // 1. Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'($urandom); cfg_period = CW'($urandom); cfg_oneshot = 1'($urandom);
            start = 1'($urandom); stop = 1'($urandom); clear = 1'($urandom);
            step();
        end
        check("rst_state", int'(state), 0);
        check("rst_count", int'(count), 0);
        check("rst_wave", int'(wave), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        cfg_valid = 0; start = 0; stop = 0; clear = 0; reset = 1;
        step();

        // 2. Periodic, period 3
        do_cfg(3, 0);
        pulse_start();
        wait_expire("per_first", 12);
        check("per_reload_count", int'(count), 3);
        check("per_wave1", int'(wave), 1);
        wait_expire("per_second", 12);
        check("per_wave2", int'(wave), 0);
        pulse_clear();

        // 3. One-shot, period 2
        do_cfg(2, 1);
        pulse_start();
        wait_expire("os_expire", 8);
        check("os_state", int'(state), 3);
        check("os_count", int'(count), 0);
        check("os_cfg_ready", int'(cfg_ready), 1);
        pulse_start();
        check("os_restart_count", int'(count), 2);
        pulse_clear();

        // 4. Pause and resume
        do_cfg(2, 0);
        pulse_start();
        s = cyc_no;
        idle(4);
        stop = 1; step(); stop = 0;
        check("pause_state", int'(state), 2);
        check("pause_count0", int'(count), 1);
        idle(9);
        check("pause_count_end", int'(count), 1);
        pulse_start();
        wait_expire("resume_expire", 4);
        check("resume_total", cyc_no - s, 19);
        pulse_clear();

        // 5a. stop coincident with a tick
        do_cfg(3, 0);
        pulse_start();
        idle(3);
        stop = 1; step(); stop = 0;
        check("stoptick_count", int'(count), 3);
        pulse_start();
        step();
        check("resume_tick_count", int'(count), 2);
        pulse_clear();

        // 5b. clear during RUN keeps config
        do_cfg(2, 1);
        pulse_start();
        idle(2);
        pulse_clear();
        check("clear_state", int'(state), 0);
        check("clear_count", int'(count), 0);
        pulse_start();
        check("clear_keep_count", int'(count), 2);
        wait_expire("clear_keep_expire", 8);
        check("clear_keep_oneshot", int'(state), 3);
        pulse_clear();

        // 5c. period 0 start ignored
        do_cfg(0, 0);
        pulse_start();
        check("zero_state", int'(state), 0);

        // 5d. cfg and start together: bypass
        cfg_valid = 1; cfg_period = CW'(5); cfg_oneshot = 0; start = 1;
        step();
        cfg_valid = 0; start = 0;
        check("bypass_state", int'(state), 1);
        check("bypass_count", int'(count), 5);
        pulse_clear();

        // Maximum period
        do_cfg(65535, 0);
        pulse_start();
        check("max_count", int'(count), 65535);
        idle(4);
        check("max_dec", int'(count), 65534);
        pulse_clear();

        // 6. Period 1, then reset right on an expiring edge
        do_cfg(1, 0);
        pulse_start();
        wait_expire("p1_first", 4);
        wait_expire("p1_second", 4);
        idle(3);
        reset = 0; step();
        check("midrst_state", int'(state), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_expire", int'(expire), 0);
        check("midrst_wave", int'(wave), 0);
        reset = 1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 149) != 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_period  = ($urandom_range(0, 15) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
            cfg_oneshot = 1'($urandom_range(0, 1));
            clear       = ($urandom_range(0, 39) == 0);
            stop        = ($urandom_range(0, 15) == 0);
            start       = !stop && ($urandom_range(0, 5) == 0);
            step();
        end
        cfg_valid = 0; start = 0; stop = 0; clear = 0; reset = 1;
        idle(2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable interval timer controller for the 50 MHz board clock. Divides clk to a tick rate, counts a loaded period of ticks, and emits an expire pulse plus a toggling square wave. Supports one-shot and periodic modes with start/stop(pause)/clear control. Sequences the shared prescaler/counter timebase for display, stopwatch and blink logic.

Parameters:
CLK_HZ, 50_000_000, input clock frequency.
TICK_HZ, 1000, tick rate. PRE = CLK_HZ/TICK_HZ must be an integer of at least 2.
CW, 16, width of the period and count.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low (0 = reset)
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted this cycle if cfg_valid
cfg_period  in  CW  period in ticks
cfg_oneshot  in  1  1 = stop after one expiry
start  in  1  start / resume strobe
stop  in  1  pause strobe
clear  in  1  abort to IDLE
expire  out  1  one-cycle pulse per period completion
wave  out  1  toggles on every expire
busy  out  1  state is RUN or PAUSE
count  out  CW  remaining ticks
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (reset==0 at a clk edge) clears all of the following:
  - state=IDLE, count=0, expire=0, wave=0
  - period_reg=0, oneshot_reg=0, prescaler=0
- Reset has top priority.
- cfg_ready = (state==IDLE || state==DONE), combinational. cfg_valid&&cfg_ready latches cfg_period and cfg_oneshot.
- Control priority per cycle: clear > stop > start > tick.
- clear:
  - Any state goes to IDLE.
  - count=0, prescaler=0. Config is retained.
  - clear does not touch wave.
- start:
  - In IDLE or DONE: goes to RUN, count=period, prescaler=0.
  - If cfg is accepted in the same cycle, start uses the new period (bypass).
  - Ignored if the effective period==0; state stays put.
  - In PAUSE: goes to RUN, count and prescaler retained (resume).
  - Ignored in RUN.
- stop:
  - In RUN: goes to PAUSE. Count and prescaler freeze.
  - A tick coincident with stop is discarded. The prescaler holds at PRE-1, so resume produces a tick in the first RUN cycle.
  - Ignored in other states.
- Prescaler:
  - Counts 0..PRE-1 only in RUN and wraps to 0.
  - tick = (prescaler==PRE-1) && state==RUN, combinational.
- On tick in RUN:
  - count>1: count decrements.
  - count==1, periodic: count=period_reg, expire=1 next cycle, wave toggles, stays in RUN.
  - count==1, oneshot: count=0, expire=1, wave toggles, state=DONE.
- expire is registered and high exactly 1 cycle.
- Latency: with start sampled at edge 0 and no stop, the first expire is high in the cycle after edge period*PRE. Periodic expires are then every period*PRE cycles exactly, with no gap cycle at reload.
- Period = 1: expire every PRE cycles.
- Period = 2^CW-1: no overflow.
- Count arithmetic is unsigned CW-bit and never underflows.
- busy = state is RUN or PAUSE.

Decomposition:
- Package timer_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and a function computing PRE and its width via $clog2.
- One sub-module, timer_prescaler:
  - Parameterised modulus, synchronous active-low reset, enable, sync clear.
  - Outputs a terminal-count pulse qualified by enable.
- The FSM and tick counter live in timer_ctrl.

Test Plan:
All scenarios use CLK_HZ=8, TICK_HZ=2, so PRE=4.
1. Reset asserted for 3 cycles with random inputs -> state=0, count=0, expire=0, wave=0, cfg_ready=1.
2. Periodic: cfg period=3 oneshot=0, then start -> expire pulses exactly 12 cycles after start, then every 12 cycles; wave toggles each time; count reloads to 3 with no gap.
3. Oneshot: period=2, start -> single expire 8 cycles after start; state=DONE; count=0; cfg_ready=1. A further start restarts with count=2.
4. Pause/resume: period=2, stop 5 cycles after start, hold 10 cycles, then start -> count stays frozen during PAUSE; expire arrives 8+10+1 cycles after the original start (total RUN time 8).
5. Edge cases:
   - stop coincident with a tick: that tick is dropped, and the first cycle after resume ticks.
   - clear during RUN goes to IDLE and keeps the config.
   - start with period=0 is ignored.
   - cfg plus start in the same cycle uses the new period.
6. Mid-operation reset deassert/reassert while in RUN -> all outputs return to reset values on the next edge, and no expire is emitted.
